inverse_peres_pipe: RTL and testbench

Pipelined, backpressure-aware inverse Peres gate that turns streams of Peres-encoded vectors (P, Q, R) back into the original (A, B, C) operands. It is the decoding end of the reversible-logic datapath. Upstream forward Peres stages produce the encoded triples; this block restores the operands for checking or further processing. Each lane is independent and bitwise: A = P, B = P ^ Q, C = R ^ (A & B).

---
 rtl/reversible_pkg.sv | 51 +++++
 rtl/rl_pipe_reg.sv | 42 ++++
 rtl/inverse_peres_pipe.sv | 93 +++++++++
 tb/tb_inverse_peres_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reversible_pkg.sv
// reversible_pkg -- shared definitions for the reversible-logic datapath.
//
// Purpose:
//   Peres gate encode/decode reference functions and a triple container
//   type. Words are PKG_W bits wide; narrower datapaths zero-extend on the
//   way in and truncate on the way out. The inverse is provided both whole
//   (peres_inv) and as its two halves (peres_inv_b, peres_inv_c) so a
//   pipelined decoder can place the halves in separate stages.
// Ports: none (package).
package reversible_pkg;

  localparam int PKG_W = 64;

  typedef logic [PKG_W-1:0] word_t;

  // Generic (x, y, z) triple: (a, b, c) operands or (p, q, r) encoding.
  typedef struct packed {
    word_t x;
    word_t y;
    word_t z;
  } triple_t;

  // Forward Peres gate: p = a, q = a ^ b, r = (a & b) ^ c.
  function automatic triple_t peres_fwd(word_t a, word_t b, word_t c);
    triple_t t;
    t.x = a;
    t.y = a ^ b;
    t.z = (a & b) ^ c;
    return t;
  endfunction

  // First decode half: recovers b from p and q.
  function automatic word_t peres_inv_b(word_t p, word_t q);
    return p ^ q;
  endfunction

  // Second decode half: recovers c once a and b are known.
  function automatic word_t peres_inv_c(word_t r, word_t a, word_t b);
    return r ^ (a & b);
  endfunction

  // Inverse Peres gate: a = p, b = p ^ q, c = r ^ (a & b).
  function automatic triple_t peres_inv(word_t p, word_t q, word_t r);
    triple_t t;
    t.x = p;
    t.y = peres_inv_b(p, q);
    t.z = peres_inv_c(r, t.x, t.y);
    return t;
  endfunction

endpackage

// File: rtl/rl_pipe_reg.sv
// rl_pipe_reg -- one valid/ready pipeline register slice.
//
// Purpose:
//   Holds one payload word. Loads whenever it is empty or its current word
//   is leaving this cycle, so bubbles collapse. No skid buffer: in_ready is
//   combinational from out_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_data   [W]       upstream payload
//   out_valid/out_ready downstream handshake
//   out_data  [W]       registered payload
module rl_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data register is cleared too (not just valid) so the
      // outputs read zero out of reset instead of stale contents.
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/inverse_peres_pipe.sv
// inverse_peres_pipe -- two-stage, backpressure-aware inverse Peres decoder.
//
// Purpose:
//   Turns encoded (P, Q, R) triples back into (A, B, C), lane by lane:
//   A = P, B = P ^ Q, C = R ^ (A & B). Stage 1 registers A, B and R;
//   stage 2 computes C from the stage-1 registers and holds the result.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready low during reset)
//   in_p, in_q, in_r [WIDTH] encoded triple
//   out_valid/out_ready      output handshake
//   out_a, out_b, out_c      recovered operands
//   word_cnt [CNT_W]         output transfers since reset, wrapping
module inverse_peres_pipe
  import reversible_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_q,
  input  logic [WIDTH-1:0] in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int PW = 3 * WIDTH;

  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] c_next;
  logic [WIDTH-1:0] a1, b1, r1;
  logic [PW-1:0]    s1_data;
  logic [PW-1:0]    s2_data;
  logic             s1_ready;
  logic             v1;
  logic             s2_ready;

  // First decode half ahead of stage 1.
  assign b_next = WIDTH'(peres_inv_b(word_t'(in_p), word_t'(in_q)));

  rl_pipe_reg #(.W(PW)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s1_ready),
    .in_data   ({in_p, b_next, in_r}),
    .out_valid (v1),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign a1 = s1_data[PW-1 -: WIDTH];
  assign b1 = s1_data[2*WIDTH-1 -: WIDTH];
  assign r1 = s1_data[WIDTH-1:0];

  // Second decode half between the stages, using the registered A and B.
  assign c_next = WIDTH'(peres_inv_c(word_t'(r1), word_t'(a1), word_t'(b1)));

  rl_pipe_reg #(.W(PW)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .in_ready  (s2_ready),
    .in_data   ({a1, b1, c_next}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_a = s2_data[PW-1 -: WIDTH];
  assign out_b = s2_data[2*WIDTH-1 -: WIDTH];
  assign out_c = s2_data[WIDTH-1:0];

  // Masked during reset so nothing is handed over while state is clearing.
  assign in_ready = s1_ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_inverse_peres_pipe.sv
// tb_inverse_peres_pipe -- self-checking bench for inverse_peres_pipe.
//
// Purpose:
//   Encodes operand triples with peres_fwd, drives them in, and compares
//   every output transfer against a queue of the original operands. A
//   second instance with CNT_W=4 exercises counter wrap.
// Ports: none (top-level bench).
module tb_inverse_peres_pipe;
  import reversible_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } ops_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_p, in_q, in_r, out_a, out_b, out_c;
  logic [15:0]   word_cnt;

  logic          in_valid2, in_ready2, out_valid2, out_ready2;
  logic [W-1:0]  in_p2, in_q2, in_r2, out_a2, out_b2, out_c2;
  logic [3:0]    word_cnt2;

  inverse_peres_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_q(in_q), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .word_cnt(word_cnt)
  );

  inverse_peres_pipe #(.WIDTH(W), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_p(in_p2), .in_q(in_q2), .in_r(in_r2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_a(out_a2), .out_b(out_b2), .out_c(out_c2),
    .word_cnt(word_cnt2)
  );

  ops_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   xfer2 = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input ops_t o);
    triple_t t;
    t = peres_fwd(word_t'(o.a), word_t'(o.b), word_t'(o.c));
    in_p = t.x[W-1:0];
    in_q = t.y[W-1:0];
    in_r = t.z[W-1:0];
    in_valid = 1'b1;
  endtask

  // Holds one word until accepted; returns the number of stalled cycles.
  task automatic send(input ops_t o, output int waits);
    bit done;
    done = 0;
    waits = 0;
    present(o);
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(o);
        done = 1;
      end else begin
        waits++;
        if (waits > 200) begin
          check("send_timeout", 64'(waits), 64'd0);
          done = 1;
        end
      end
      step();
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Output scoreboard: every transfer must match the oldest expected word,
  // and word_cnt must equal the transfers seen before this cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("cnt", 64'(word_cnt), 64'(16'(exp_cnt)));
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          ops_t e;
          e = sb.pop_front();
          check("data", 64'({out_a, out_b, out_c}), 64'(e));
        end
        exp_cnt++;
      end
      if (out_valid2 && out_ready2) xfer2++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   waits, stalls, idx, n;
    bit   pending, have_hold;
    ops_t o, held;
    int   exp_wrap;

    rst = 1'b1;
    in_valid = 1'b0; in_p = '0; in_q = '0; in_r = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_p2 = '0; in_q2 = '0; in_r2 = '0; out_ready2 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    check("rst_out_data", 64'({out_a, out_b, out_c}), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    step();

    // Single word with the documented encoding, then latency and count.
    out_ready = 1'b1;
    in_p = 8'hA5; in_q = 8'h99; in_r = 8'h2B; in_valid = 1'b1;
    @(negedge clk);
    check("single_accept", 64'(in_ready), 64'd1);
    sb.push_back('{a: 8'hA5, b: 8'h3C, c: 8'h0F});
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_s1_only", 64'(out_valid), 64'd0);
    step();
    @(negedge clk);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    step();
    @(negedge clk);
    check("single_cnt", 64'(word_cnt), 64'd1);
    step();

    // Back-to-back stream of 256 words, no stalls expected.
    stalls = 0;
    for (int i = 0; i < 256; i++) begin
      o = '{a: 8'(i), b: 8'(i), c: 8'(i)};
      send(o, waits);
      stalls += waits;
    end
    in_valid = 1'b0;
    drain("stream_drain");
    check("stream_stalls", 64'(stalls), 64'd0);
    @(negedge clk);
    check("stream_cnt", 64'(word_cnt), 64'd257);
    step();

    // Output stall: exactly two words fit, output data holds.
    out_ready = 1'b0;
    idx = 0;
    have_hold = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      present('{a: 8'(8'h40 + idx), b: 8'(8'h80 + idx), c: 8'(8'hC0 + idx)});
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{a: 8'(8'h40 + idx), b: 8'(8'h80 + idx), c: 8'(8'hC0 + idx)});
        idx++;
      end
      if (out_valid) begin
        if (have_hold) check("stall_hold", 64'({out_a, out_b, out_c}), 64'(held));
        else begin
          held = '{a: out_a, b: out_b, c: out_c};
          have_hold = 1;
        end
      end
      step();
    end
    @(negedge clk);
    check("stall_accepted", 64'(idx), 64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    step();
    out_ready = 1'b1;
    n = 0;
    while (idx < 3 && n < 50) begin
      present('{a: 8'(8'h40 + idx), b: 8'(8'h80 + idx), c: 8'(8'hC0 + idx)});
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{a: 8'(8'h40 + idx), b: 8'(8'h80 + idx), c: 8'(8'hC0 + idx)});
        idx++;
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    drain("stall_drain");

    // Random valid/ready toggling over 10k words.
    n = 0;
    pending = 0;
    for (int cyc = 0; cyc < 60000 && n < 10000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 3) != 0) begin
        o = '{a: 8'($urandom), b: 8'($urandom), c: 8'($urandom)};
        present(o);
        pending = 1;
      end
      in_valid = pending;
      @(negedge clk);
      if (pending && in_ready) begin
        sb.push_back(o);
        pending = 0;
        n++;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");
    check("rand_words", 64'(n), 64'd10000);
    @(negedge clk);
    check("rand_cnt", 64'(word_cnt), 64'(16'(257 + 3 + 10000)));
    step();

    // Reset with two words in flight: they must vanish.
    out_ready = 1'b0;
    send('{a: 8'h11, b: 8'h22, c: 8'h33}, waits);
    send('{a: 8'h44, b: 8'h55, c: 8'h66}, waits);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    check("mr_in_ready_rst", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_word_cnt", 64'(word_cnt), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("mr_no_ghost", 64'(word_cnt), 64'd0);
    step();

    // Counter wrap on the CNT_W=4 instance.
    n = 0;
    stalls = 0;
    while (n < 17 && stalls < 100) begin
      in_p2 = 8'(n); in_q2 = 8'(n * 3); in_r2 = 8'(n * 5);
      in_valid2 = 1'b1;
      @(negedge clk);
      if (in_ready2) n++;
      else stalls++;
      step();
    end
    in_valid2 = 1'b0;
    repeat (4) step();
    exp_wrap = 17 % 16;
    @(negedge clk);
    check("wrap_xfers", 64'(xfer2), 64'd17);
    check("wrap_cnt", 64'(word_cnt2), 64'(exp_wrap));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
